slot_alloc_ctrl: RTL and testbench
==================================

Name: slot_alloc_ctrl

Overview:
- Allocator/controller for a 64-entry shared resource pool (scheduler slots, tags) indexed 0..63.
- Keeps a free bitmap and picks the lowest-numbered free slot with a 64-bit find-first-set index search.
- Shares allocation between two requesters with round-robin arbitration and a reserve watermark.
- Returns slots through a free port or a global flush.

Parameters:
- RESERVE, 4: requester 1 is granted only while free_count > RESERVE. Legal range 0..63.
- ENTRIES, 64: pool size. Fixed at 64; any other value is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 wants a slot; held until acked
- req0_ack  out  1  combinational; req0 granted this cycle
- req1_valid  in  1  requester 1 wants a slot; held until acked
- req1_ack  out  1  combinational; req1 granted this cycle
- gnt_valid  out  1  registered; a slot was granted in the previous cycle
- gnt_id  out  1  registered; requester that received the slot
- gnt_index  out  6  registered; granted slot index
- free_valid  in  1  return a slot
- free_index  in  6  slot being returned
- flush  in  1  return all slots
- free_map  out  64  registered; bit i = 1 means slot i is free
- free_count  out  7  registered; number of set bits in free_map, 0..64
- empty  out  1  combinational; free_count == 0
- err_double_free  out  1  registered; one-cycle pulse

Behaviour:
- Reset (synchronous, active-high, in effect on the edge where rst=1):
  - free_map = all ones; free_count = 64.
  - rr_last = 1, so requester 0 wins the first tie.
  - gnt_valid = 0, gnt_id = 0, gnt_index = 0, err_double_free = 0.
  - While rst is high, both acks are 0.
  - Reset mid-operation discards all allocations; no grants issue in the reset cycle.
- Find: pick = index of the lowest set bit of the registered free_map; any_free = |free_map.
  - The search is purely combinational on register state.
  - No bypass: a slot freed in cycle t becomes allocatable in t+1.
- Eligibility:
  - elig0 = req0_valid & any_free & ~flush & ~rst.
  - elig1 = req1_valid & any_free & (free_count > RESERVE) & ~flush & ~rst.
- Arbitration: at most one grant per cycle.
  - Only one eligible requester: it wins.
  - Both eligible: the one that is not rr_last wins.
  - rr_last updates to the winner only on a grant.
  - Winning reqN_ack = 1 in the same cycle; the requester drops or renews valid after the ack.
- Grant commit, at the edge after the ack:
  - free_map[pick] <= 0.
  - gnt_valid <= 1, gnt_id <= winner, gnt_index <= pick.
  - With no grant: gnt_valid <= 0; gnt_id and gnt_index hold.
  - Grant latency is 1 cycle from ack to gnt_valid.
- Free, when free_valid & ~flush:
  - If free_map[free_index] == 0: set it to 1.
  - Else it is a double free: free_map is unchanged and err_double_free pulses the next cycle.
- Simultaneous grant and free in one cycle:
  - They always target different slots, because pick was free while free_index was allocated; the double-free case is unaffected.
  - free_count' = free_count - grant + free_ok.
- Flush:
  - Next free_map = all ones; free_count = 64.
  - No acks in the flush cycle; free_valid is ignored; no error.
  - gnt_valid <= 0.
- Pool exhausted (any_free = 0): empty = 1, both acks 0, requests stay pending; no error.
- Reserve: while free_count <= RESERVE, requester 1 stalls and requester 0 may drain the pool to 0.
- free_count never leaves 0..64; a violation is an assertion failure.

Test Plan:
- After reset, req0_valid held high for 3 cycles -> req0_ack = 1 each cycle; gnt_index = 0, 1, 2 with gnt_id = 0 on cycles 1..3; free_count = 61.
- req0 and req1 both held high from reset -> acks alternate req0, req1, req0, req1; gnt_index 0..3; gnt_id 0, 1, 0, 1.
- Allocate 0..5, then free_index = 2 in the same cycle as a req0 -> that grant gets index 6 (no bypass); the next grant gets index 2; free_count remains consistent each cycle.
- Free slot 40 while it is already free -> err_double_free = 1 for exactly one cycle; free_map and free_count unchanged.
- RESERVE = 4, allocate 60 slots via req0, then assert only req1 -> req1_ack stays 0; req0 then takes 4 more, down to 0; empty = 1; both acks 0.
- Flush asserted together with req0_valid and free_valid -> no ack; next cycle free_map = all ones, free_count = 64, gnt_valid = 0; rst in the middle of an allocation burst -> same state as power-on reset.

Source files
------------

// File: rtl/slot_alloc_ctrl.sv
// rtl/slot_alloc_ctrl.sv - 64-entry slot allocator with round-robin arbitration and reserve watermark
// Lowest-free-first allocation from a free bitmap, shared by two requesters, with free/flush return.
module slot_alloc_ctrl #(
  parameter int RESERVE = 4,
  parameter int ENTRIES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ack,
  input  logic               req1_valid,
  output logic               req1_ack,
  output logic               gnt_valid,
  output logic               gnt_id,
  output logic [5:0]         gnt_index,
  input  logic               free_valid,
  input  logic [5:0]         free_index,
  input  logic               flush,
  output logic [ENTRIES-1:0] free_map,
  output logic [6:0]         free_count,
  output logic               empty,
  output logic               err_double_free
);

  localparam logic [6:0] RSV = 7'(RESERVE);

  logic               rr_last;
  logic [5:0]         pick;
  logic               any_free;
  logic               elig0;
  logic               elig1;
  logic               grant;
  logic               free_hit;
  logic               free_ok;
  logic               dbl_free;
  logic [ENTRIES-1:0] map_nxt;

  // Scan high to low so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    pick = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_map[i]) pick = 6'(i);
    end
  end

  assign any_free = |free_map;
  assign empty    = (free_count == 7'd0);

  assign elig0 = req0_valid & any_free & ~flush & ~rst;
  assign elig1 = req1_valid & any_free & (free_count > RSV) & ~flush & ~rst;

  // rr_last names the previous winner; the other side wins a tie.
  assign req0_ack = elig0 & (~elig1 | rr_last);
  assign req1_ack = elig1 & (~elig0 | ~rr_last);
  assign grant    = req0_ack | req1_ack;

  assign free_hit = free_map[free_index];
  assign free_ok  = free_valid & ~flush & ~free_hit;
  assign dbl_free = free_valid & ~flush & free_hit;

  // A granted slot was free and a legally freed slot was allocated, so the two never collide.
  always_comb begin
    map_nxt = free_map;
    if (grant)   map_nxt[pick]       = 1'b0;
    if (free_ok) map_nxt[free_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map        <= '1;
      free_count      <= 7'd64;
      rr_last         <= 1'b1;
      gnt_valid       <= 1'b0;
      gnt_id          <= 1'b0;
      gnt_index       <= '0;
      err_double_free <= 1'b0;
    end else if (flush) begin
      free_map        <= '1;
      free_count      <= 7'd64;
      gnt_valid       <= 1'b0;
      err_double_free <= 1'b0;
    end else begin
      free_map        <= map_nxt;
      free_count      <= free_count - 7'(grant) + 7'(free_ok);
      gnt_valid       <= grant;
      err_double_free <= dbl_free;
      if (grant) begin
        rr_last   <= req1_ack;
        gnt_id    <= req1_ack;
        gnt_index <= pick;
      end
    end
  end

  count_range: assert property (@(posedge clk) disable iff (rst) free_count <= 7'd64);

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// tb/tb_slot_alloc_ctrl.sv - randomized self-checking bench for slot_alloc_ctrl
// A per-slot free array plus last-winner model predicts acks and registered outputs every cycle.
module tb_slot_alloc_ctrl;

  localparam int RESERVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic        free_valid = 1'b0;
  logic [5:0]  free_index = '0;
  logic        flush = 1'b0;
  logic        req0_ack;
  logic        req1_ack;
  logic        gnt_valid;
  logic        gnt_id;
  logic [5:0]  gnt_index;
  logic [63:0] free_map;
  logic [6:0]  free_count;
  logic        empty;
  logic        err_double_free;

  always #5 clk = ~clk;

  slot_alloc_ctrl #(.RESERVE(RESERVE), .ENTRIES(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_ack(req1_ack),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_index(gnt_index),
    .free_valid(free_valid), .free_index(free_index), .flush(flush),
    .free_map(free_map), .free_count(free_count), .empty(empty),
    .err_double_free(err_double_free)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit mfree [64];
  int mlast = 1;
  bit mgv   = 0;
  int mgid  = 0;
  int mgidx = 0;
  bit merr  = 0;
  bit last_a0 = 0;
  bit last_a1 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nfree();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(mfree[i]);
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 64; i++) if (mfree[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] exp_map();
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = mfree[i];
    return m;
  endfunction

  task automatic step(input bit r, input bit v0, input bit v1, input bit fv, input int fi, input bit fl);
    bit e0, e1, a0, a1;
    int p;
    @(negedge clk);
    rst = r; req0_valid = v0; req1_valid = v1;
    free_valid = fv; free_index = 6'(fi); flush = fl;
    #1;
    p  = lowest_free();
    e0 = v0 && !r && !fl && (p >= 0);
    e1 = v1 && !r && !fl && (p >= 0) && (nfree() > RESERVE);
    a0 = e0 && (!e1 || mlast == 1);
    a1 = e1 && (!e0 || mlast == 0);
    check("req0_ack", req0_ack, a0);
    check("req1_ack", req1_ack, a1);
    check("empty_pre", empty, nfree() == 0);
    last_a0 = a0;
    last_a1 = a1;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 64; i++) mfree[i] = 1'b1;
      mlast = 1; mgv = 0; mgid = 0; mgidx = 0; merr = 0;
    end else if (fl) begin
      for (int i = 0; i < 64; i++) mfree[i] = 1'b1;
      mgv = 0; merr = 0;
    end else begin
      merr = 0;
      if (fv) begin
        if (mfree[fi]) merr = 1;
        else mfree[fi] = 1'b1;
      end
      if (a0 || a1) begin
        mfree[p] = 1'b0;
        mgv   = 1;
        mgid  = a1 ? 1 : 0;
        mgidx = p;
        mlast = mgid;
      end else begin
        mgv = 0;
      end
    end
    check("gnt_valid", gnt_valid, mgv);
    check("gnt_id", gnt_id, 64'(mgid));
    check("gnt_index", gnt_index, 64'(mgidx));
    check("err_double_free", err_double_free, merr);
    check("free_map", free_map, exp_map());
    check("free_count", free_count, 64'(nfree()));
    check("empty", empty, nfree() == 0);
  endtask

  initial begin
    bit v0, v1, r, fl, fv;
    int fi;
    int alloc_q [$];

    for (int i = 0; i < 64; i++) mfree[i] = 1'b1;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_count", free_count, 64);
    check("reset_map", free_map, {64{1'b1}});

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    check("three_grants_count", free_count, 61);
    check("three_grants_index", gnt_index, 2);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
    check("alt_last_id", gnt_id, 1);
    check("alt_last_index", gnt_index, 3);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 2, 0);
    check("no_bypass_index", gnt_index, 6);
    step(0, 1, 0, 0, 0, 0);
    check("refill_index", gnt_index, 2);

    step(0, 0, 0, 1, 40, 0);
    check("dbl_free_pulse", err_double_free, 1);
    step(0, 0, 0, 0, 0, 0);
    check("dbl_free_clear", err_double_free, 0);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    check("reserve_count", free_count, 4);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    check("drained_count", free_count, 0);
    step(0, 1, 1, 0, 0, 0);
    check("drained_empty", empty, 1);

    step(0, 1, 0, 1, 3, 1);
    check("flush_count", free_count, 64);
    check("flush_gnt_valid", gnt_valid, 0);

    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    check("mid_reset_map", free_map, {64{1'b1}});

    v0 = 0; v1 = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 499) == 0);
      fl = ($urandom_range(0, 199) == 0);
      if (!v0 || last_a0) v0 = ($urandom_range(0, 3) != 0);
      if (!v1 || last_a1) v1 = ($urandom_range(0, 3) != 0);
      if (((c / 400) % 2) == 1) fv = ($urandom_range(0, 9) < 8);
      else fv = ($urandom_range(0, 9) < 3);
      alloc_q.delete();
      for (int i = 0; i < 64; i++) if (!mfree[i]) alloc_q.push_back(i);
      if (alloc_q.size() > 0 && $urandom_range(0, 7) != 0)
        fi = alloc_q[$urandom_range(0, alloc_q.size() - 1)];
      else
        fi = int'($urandom_range(0, 63));
      step(r, v0, v1, fv, fi, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
